// File: rtl/line_decoder_pkg.sv
// line_decoder_pkg: shared FSM state type and mode encodings for the scanning line decoder
package line_decoder_pkg;

    typedef enum logic [1:0] {
        S_OFF,
        S_DIRECT,
        S_DWELL,
        S_BLANK
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/line_decoder_seq_if.sv
// line_decoder_seq_if: control inputs and decoded outputs of line_decoder_seq
// Members: select_i, mode_i, dwell_i, g1_en_i, g2a_en_n_i, g2b_en_n_i (to decoder);
//          yn_o, index_o, wrap_o (from decoder).
// Modports: master drives the controls, slave is the decoder.
interface line_decoder_seq_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
);
    logic [SEL_W-1:0]      select_i;
    logic                  mode_i;
    logic [DWELL_W-1:0]    dwell_i;
    logic                  g1_en_i;
    logic                  g2a_en_n_i;
    logic                  g2b_en_n_i;
    logic [2**SEL_W-1:0]   yn_o;
    logic [SEL_W-1:0]      index_o;
    logic                  wrap_o;

    modport master (
        output select_i, mode_i, dwell_i, g1_en_i, g2a_en_n_i, g2b_en_n_i,
        input  yn_o, index_o, wrap_o
    );

    modport slave (
        input  select_i, mode_i, dwell_i, g1_en_i, g2a_en_n_i, g2b_en_n_i,
        output yn_o, index_o, wrap_o
    );
endinterface

// File: rtl/line_decode_comb.sv
// line_decode_comb: pure SEL_W-to-2**SEL_W active-low decode with enable
// Ports: sel line select; en drives the selected line when high; yn active-low lines,
//        line k on yn[2**SEL_W-1-k] so line 0 is the MSB.
module line_decode_comb #(
    parameter int SEL_W = 3
)(
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic [2**SEL_W-1:0] yn
);
    localparam int OUT_N = 2**SEL_W;

    for (genvar k = 0; k < OUT_N; k++) begin : g_line
        assign yn[OUT_N-1-k] = ~(en && sel == SEL_W'(k));
    end
endmodule

// File: rtl/line_decoder_seq.sv
// line_decoder_seq: registered active-low line decoder with direct select and timed auto-scan
// Ports: clk_i rising-edge clock; rst_n_i async active-low reset;
//        bus (slave) carries select/mode/dwell/enable inputs and yn/index/wrap outputs.
module line_decoder_seq
    import line_decoder_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
)(
    input logic clk_i,
    input logic rst_n_i,
    line_decoder_seq_if.slave bus
);
    localparam int OUT_N   = 2**SEL_W;
    localparam int BLANK_W = BLANK_CYC > 1 ? $clog2(BLANK_CYC) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);

    state_t             state, nxt_state;
    logic [DWELL_W-1:0] dwell_cnt, nxt_dwell;
    logic [BLANK_W-1:0] blank_cnt, nxt_blank;
    logic [SEL_W-1:0]   nxt_idx;
    logic               nxt_lit, nxt_wrap, en;
    logic [OUT_N-1:0]   dec_yn;

    assign en = bus.g1_en_i & ~bus.g2a_en_n_i & ~bus.g2b_en_n_i;

    // Next line and whether it is lit; the decoder output is then registered so
    // every output comes straight from a flop.
    always_comb begin
        nxt_state = S_OFF;
        nxt_idx   = bus.index_o;
        nxt_lit   = 1'b0;
        nxt_wrap  = 1'b0;
        nxt_dwell = '0;
        nxt_blank = '0;
        if (!en) begin
            nxt_state = S_OFF;
        end else if (bus.mode_i == MODE_DIRECT) begin
            nxt_state = S_DIRECT;
            nxt_idx   = bus.select_i;
            nxt_lit   = 1'b1;
        end else if (state == S_OFF || state == S_DIRECT) begin
            nxt_state = S_DWELL;
            nxt_idx   = '0;
            nxt_lit   = 1'b1;
        end else if (state == S_DWELL && dwell_cnt < bus.dwell_i) begin
            nxt_state = S_DWELL;
            nxt_dwell = dwell_cnt + 1'b1;
            nxt_lit   = 1'b1;
        end else if (state == S_DWELL && BLANK_CYC > 0) begin
            nxt_state = S_BLANK;
        end else if (state == S_BLANK && blank_cnt < BLANK_LAST) begin
            nxt_state = S_BLANK;
            nxt_blank = blank_cnt + 1'b1;
        end else begin
            // advance to the next line; index wraps naturally in SEL_W bits
            nxt_state = S_DWELL;
            nxt_idx   = bus.index_o + 1'b1;
            nxt_lit   = 1'b1;
            nxt_wrap  = &bus.index_o;
        end
    end

    line_decode_comb #(.SEL_W(SEL_W)) u_dec (
        .sel (nxt_idx),
        .en  (nxt_lit),
        .yn  (dec_yn)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_OFF;
            dwell_cnt   <= '0;
            blank_cnt   <= '0;
            bus.yn_o    <= '1;
            bus.index_o <= '0;
            bus.wrap_o  <= 1'b0;
        end else begin
            state       <= nxt_state;
            dwell_cnt   <= nxt_dwell;
            blank_cnt   <= nxt_blank;
            bus.yn_o    <= dec_yn;
            bus.index_o <= nxt_idx;
            bus.wrap_o  <= nxt_wrap;
        end
    end
endmodule

// File: doc/line_decoder_seq.md
LINE_DECODER_SEQ -- requirements
Module: line_decoder_seq

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select width; OUT_N = 2**SEL_W derived, not overridable.
REQ-002 SHALL have parameter DWELL_W, default 8, dwell-count width.
REQ-003 SHALL have parameter BLANK_CYC, default 1, all-off cycles between scan lines; 0 disables blanking.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  clock, rising edge; rst_n_i  in  1  async reset, active-low.
REQ-005 SHALL have select_i  in  SEL_W  direct-mode line select.
REQ-006 SHALL have mode_i  in  1  0 = direct, 1 = auto-scan.
REQ-007 SHALL have dwell_i  in  DWELL_W  scan dwell; each line stays active dwell_i+1 cycles.
REQ-008 SHALL have g1_en_i  in  1  enable, active-high.
REQ-009 SHALL have g2a_en_n_i and g2b_en_n_i  in  1 each  enables, active-low.
REQ-010 SHALL have yn_o  out  OUT_N  registered decoded lines, active-low.
REQ-011 SHALL have index_o  out  SEL_W  registered line index currently driven or last driven.
REQ-012 SHALL have wrap_o  out  1  one-cycle pulse on scan wrap.

Function
REQ-013 SHALL compute en = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i each cycle.
REQ-014 SHALL drive at most one yn_o bit low; line k maps to yn_o[OUT_N-1-k] (line 0 = MSB).
REQ-015 SHALL use FSM states S_OFF, S_DIRECT, S_DWELL, S_BLANK.
REQ-016 S_OFF: yn_o all ones; entered from any state when en=0; exit when en=1 to S_DIRECT (mode_i=0) or S_DWELL (mode_i=1).
REQ-017 S_DIRECT: yn_o and index_o update one cycle after select_i changes (latency 1), from registered decode of select_i.
REQ-018 S_DWELL: line index_o low; dwell counter increments per cycle; when counter >= dwell_i, go to S_BLANK (BLANK_CYC>0) or advance line directly (BLANK_CYC=0).
REQ-019 S_BLANK: yn_o all ones for exactly BLANK_CYC cycles, then S_DWELL with index_o+1 and dwell counter 0.
REQ-020 Index SHALL wrap OUT_N-1 -> 0; wrap_o high for the single cycle in which index_o first shows 0 after wrap.
REQ-021 dwell_i SHALL be compared live; a reduction below current count advances on the next cycle.
REQ-022 Entry into S_DWELL from S_OFF or S_DIRECT SHALL start at index 0, counter 0, no wrap_o pulse.
REQ-023 en=0 mid-scan SHALL force yn_o all ones next cycle and discard scan position; re-enable restarts per REQ-022.
REQ-024 mode_i 1->0 mid-scan SHALL enter S_DIRECT next cycle, no blanking cycle.
REQ-025 en=0 and mode change in the same cycle: en takes precedence (S_OFF).

Reset
REQ-026 On rst_n_i low, asynchronously: state S_OFF, yn_o all ones, index_o 0, wrap_o 0, dwell and blank counters 0.
REQ-027 Deassertion SHALL be synchronised externally; first active edge after release evaluates en normally.

Structure
REQ-028 Package line_decoder_pkg SHALL hold the FSM state enum typedef and mode constants MODE_DIRECT/MODE_SCAN.
REQ-029 Sub-module line_decode_comb SHALL implement the pure SEL_W-to-OUT_N active-low decode with enable, instantiated once.
REQ-030 All outputs SHALL be register-driven; no combinational input-to-output path.

Verification (SEL_W=3, BLANK_CYC=1)
REQ-031 Direct sweep: en=1, mode_i=0, select_i 0..7 -> yn_o 8'h7F, 8'hBF ... 8'hFE one cycle after each select.
REQ-032 Enable truth table: each of 8 en combinations with select_i=3 -> only g1=1,g2a=0,g2b=0 gives 8'hEF; others 8'hFF.
REQ-033 Scan, dwell_i=2: each line low 3 cycles, 1 all-ones cycle between; full cycle 32 clocks; wrap_o pulses once per 32.
REQ-034 Scan, dwell_i=0, BLANK_CYC=0 build: index_o increments every cycle, wrap_o every 8 cycles.
REQ-035 Mid-scan disruption: at index 5 drop g1_en_i for 1 cycle -> next cycle 8'hFF, re-enable restarts at index 0 with 8'h7F, no wrap_o.
REQ-036 Async reset asserted mid-dwell between clock edges -> yn_o 8'hFF, index_o 0 immediately without clock edge.
